// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from a single-clock FIFO and serializes them as
// UART frames (start, 8 data bits LSB first, optional even parity, 1-2 stop).
// Ports:
//   clk, rst_n   - clock (rising edge), asynchronous active-low reset
//   tx_en        - permits fetching a new byte (sampled in IDLE only)
//   fifo_empty   - FIFO empty flag (sampled in IDLE only)
//   fifo_data    - FIFO read data, valid the cycle after fifo_rd
//   fifo_rd      - registered one-cycle FIFO read strobe
//   tx           - registered serial line, idles high
//   busy         - high in every state except IDLE
//   frame_done   - one-cycle pulse in the last cycle of the final stop bit
module fifo_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_en,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    localparam int unsigned       BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_CAPTURE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t            r_state;
    logic [BAUD_W-1:0] r_baud;
    logic [2:0]        r_bit;
    logic [7:0]        r_shift;
    logic              r_par;

    state_t            w_state_nxt;
    logic [BAUD_W-1:0] w_baud_nxt;
    logic [2:0]        w_bit_nxt;
    logic [7:0]        w_shift_nxt;
    logic              w_par_nxt;
    logic              w_tx_nxt;
    logic              w_rd_nxt;
    logic              w_busy_nxt;
    logic              w_done_nxt;
    logic              w_bit_end;

    assign w_bit_end = (r_baud == BAUD_LAST);

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_baud     <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            tx         <= 1'b1;
            fifo_rd    <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_baud     <= w_baud_nxt;
            r_bit      <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
            r_par      <= w_par_nxt;
            tx         <= w_tx_nxt;
            fifo_rd    <= w_rd_nxt;
            busy       <= w_busy_nxt;
            frame_done <= w_done_nxt;
        end
    end

    // Next-state and counter logic
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_par_nxt   = r_par;

        case (r_state)
            ST_IDLE: begin
                if (tx_en && !fifo_empty) begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                w_state_nxt = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                // fifo_data is only looked at here, so junk elsewhere is harmless
                w_shift_nxt = fifo_data;
                w_par_nxt   = 1'b0;
                w_baud_nxt  = '0;
                w_bit_nxt   = '0;
                w_state_nxt = ST_START;
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_baud_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = ST_DATA;
                end else begin
                    w_baud_nxt = r_baud + BAUD_W'(1);
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    w_baud_nxt  = '0;
                    w_par_nxt   = r_par ^ r_shift[0];
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    if (r_bit == 3'd7) begin
                        w_bit_nxt   = '0;
                        w_state_nxt = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        w_bit_nxt = r_bit + 3'd1;
                    end
                end else begin
                    w_baud_nxt = r_baud + BAUD_W'(1);
                end
            end
            ST_PARITY: begin
                if (w_bit_end) begin
                    w_baud_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = ST_STOP;
                end else begin
                    w_baud_nxt = r_baud + BAUD_W'(1);
                end
            end
            ST_STOP: begin
                // Bit counter tracks which stop bit is on the line
                if (w_bit_end) begin
                    w_baud_nxt = '0;
                    if (r_bit == STOP_LAST) begin
                        w_bit_nxt   = '0;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_bit_nxt = r_bit + 3'd1;
                    end
                end else begin
                    w_baud_nxt = r_baud + BAUD_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registers line up with it
    always_comb begin
        w_tx_nxt   = 1'b1;
        w_rd_nxt   = (w_state_nxt == ST_FETCH);
        w_busy_nxt = (w_state_nxt != ST_IDLE);
        w_done_nxt = (w_state_nxt == ST_STOP) && (w_baud_nxt == BAUD_LAST) &&
                     (w_bit_nxt == STOP_LAST);
        case (w_state_nxt)
            ST_START:  w_tx_nxt = 1'b0;
            ST_DATA:   w_tx_nxt = w_shift_nxt[0];
            ST_PARITY: w_tx_nxt = w_par_nxt;
            default:   w_tx_nxt = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: randomized scoreboard bench for fifo_uart_tx. A FIFO model
// feeds the DUT; pushed bytes go into an expected queue, and a line monitor
// decodes each frame from tx and compares it with an ideal UART frame.
module tb_fifo_uart_tx;

    localparam int unsigned CPB       = 16;
    localparam int unsigned PAR       = 1;
    localparam int unsigned STOPS     = 2;
    localparam int unsigned NBITS     = 1 + 8 + PAR + STOPS;
    localparam int unsigned FRAME_LEN = NBITS * CPB;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tx_en;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_rd;
    logic       tx;
    logic       busy;
    logic       frame_done;

    fifo_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .PARITY_EN   (PAR),
        .STOP_BITS   (STOPS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tx_en     (tx_en),
        .fifo_empty(fifo_empty),
        .fifo_data (fifo_data),
        .fifo_rd   (fifo_rd),
        .tx        (tx),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // FIFO model: data appears the cycle after a read, junk otherwise
    logic [7:0]  mem [0:1023];
    int unsigned wr_ptr = 0;
    int unsigned rd_ptr = 0;
    logic [7:0]  exp_q [$];

    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_rd === 1'b1 && rd_ptr != wr_ptr) begin
            fifo_data <= mem[rd_ptr % 1024];
            rd_ptr    <= rd_ptr + 1;
        end else begin
            fifo_data <= 8'($urandom);
        end
    end

    task automatic push(input logic [7:0] b);
        mem[wr_ptr % 1024] = b;
        wr_ptr = wr_ptr + 1;
        exp_q.push_back(b);
    endtask

    // Read strobe and frame_done bookkeeping
    int unsigned rd_cnt = 0;
    int unsigned done_cnt = 0;
    logic        prev_rd = 1'b0;

    always @(negedge clk) begin
        if (fifo_rd === 1'b1) begin
            rd_cnt++;
            chk("rd_pulse_width", 32'(prev_rd), 32'd0);
            chk("rd_when_empty", 32'(wr_ptr != rd_ptr), 32'd1);
        end
        if (frame_done === 1'b1) done_cnt++;
        prev_rd = fifo_rd;
    end

    // Line monitor
    int unsigned frames_started = 0;
    int unsigned frames_seen = 0;
    int unsigned last_start_cyc = 0;
    int unsigned m_last_end = 0;
    bit          gap_chk = 1'b0;
    logic [7:0]  m_byte;
    logic        fbits [0:NBITS-1];
    int unsigned m_errs;
    int          m_first_bad;
    bit          m_abort;

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx === 1'b0) begin
                frames_started++;
                if (gap_chk) chk("frame_gap", 32'(cyc - m_last_end - 1), 32'd3);
                last_start_cyc = cyc;
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", 32'd1, 32'd0);
                    m_byte = 8'h00;
                end else begin
                    m_byte = exp_q.pop_front();
                end
                fbits[0] = 1'b0;
                for (int i = 0; i < 8; i++) fbits[1 + i] = m_byte[i];
                if (PAR != 0) fbits[9] = ^m_byte;
                for (int i = 9 + PAR; i < NBITS; i++) fbits[i] = 1'b1;
                m_errs = 0;
                m_first_bad = -1;
                m_abort = 1'b0;
                for (int k = 0; k < FRAME_LEN; k++) begin
                    if (k != 0) @(negedge clk);
                    if (rst_n !== 1'b1) begin
                        m_abort = 1'b1;
                        break;
                    end
                    if (tx !== fbits[k / CPB] || frame_done !== (k == FRAME_LEN - 1) ||
                        busy !== 1'b1) begin
                        if (m_errs == 0) m_first_bad = k;
                        m_errs++;
                    end
                end
                if (!m_abort) begin
                    frames_seen++;
                    n_checks++;
                    if (m_errs != 0) begin
                        n_errors++;
                        $display("FAIL frame %02h: %0d bad cycles, first at frame cycle %0d, expected 0 bad cycles",
                                 m_byte, m_errs, m_first_bad);
                    end
                    m_last_end = cyc;
                    @(negedge clk);
                    chk("post_frame_busy", 32'(busy), 32'd0);
                    chk("post_frame_tx", 32'(tx), 32'd1);
                end
            end
        end
    end

    task automatic wait_frames(input int unsigned target, input string name);
        int unsigned n = 0;
        int unsigned budget = (target - frames_seen + 1) * (FRAME_LEN + 3) + 100;
        while (frames_seen < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (frames_seen < target) begin
            n_errors++;
            $display("FAIL %s: timed out with %0d frames, expected %0d", name, frames_seen, target);
        end
    endtask

    task automatic wait_start(input int unsigned s0);
        int unsigned n = 0;
        while (frames_started == s0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("start_seen", 32'(frames_started != s0), 32'd1);
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    initial begin : watchdog
        #(600000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        int unsigned p_cyc, r0, f0, s0;
        rst_n = 1'b0;
        tx_en = 1'b0;

        // Reset values with random inputs
        repeat (8) begin
            @(negedge clk);
            tx_en = 1'($urandom);
            #1;
            chk("rst_tx", 32'(tx), 32'd1);
            chk("rst_rd", 32'(fifo_rd), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_done", 32'(frame_done), 32'd0);
        end
        @(negedge clk);
        tx_en = 1'b1;
        #2 rst_n = 1'b1;
        idle(100);
        chk("empty_no_rd", rd_cnt, 32'd0);
        chk("empty_tx_idle", 32'(tx), 32'd1);
        chk("empty_busy", 32'(busy), 32'd0);

        // Single byte: latency, one read, full frame
        p_cyc = cyc;
        push(8'hA5);
        wait_frames(1, "single_byte");
        chk("single_latency", last_start_cyc - p_cyc, 32'd3);
        chk("single_rd", rd_cnt, 32'd1);

        // Parity bytes back to back
        idle(10);
        f0 = frames_seen;
        push(8'h07);
        push(8'h00);
        wait_frames(f0 + 1, "parity_first");
        gap_chk = 1'b1;
        wait_frames(f0 + 2, "parity_second");
        gap_chk = 1'b0;

        // Back-to-back drain of a full FIFO
        idle(10);
        f0 = frames_seen;
        r0 = rd_cnt;
        for (int i = 0; i < 64; i++) push(8'($urandom));
        wait_frames(f0 + 1, "drain_first");
        gap_chk = 1'b1;
        wait_frames(f0 + 64, "drain_all");
        gap_chk = 1'b0;
        idle(3);
        chk("drain_rd", rd_cnt - r0, 32'd64);
        chk("drain_empty", 32'(fifo_empty), 32'd1);
        chk("drain_busy", 32'(busy), 32'd0);

        // tx_en dropped mid-frame
        idle(5);
        f0 = frames_seen;
        r0 = rd_cnt;
        s0 = frames_started;
        for (int i = 0; i < 3; i++) push(8'($urandom));
        wait_start(s0);
        idle(3 * CPB + $urandom_range(0, CPB - 1));
        tx_en = 1'b0;
        wait_frames(f0 + 1, "txen_current");
        idle(60);
        chk("txen_rd_held", rd_cnt - r0, 32'd1);
        chk("txen_no_start", frames_started - s0, 32'd1);
        chk("txen_busy", 32'(busy), 32'd0);
        s0 = frames_started;
        p_cyc = cyc;
        tx_en = 1'b1;
        wait_start(s0);
        chk("txen_resume_latency", last_start_cyc - p_cyc, 32'd3);
        wait_frames(f0 + 3, "txen_rest");

        // Reset during bit 4 of 0x3C
        idle(5);
        f0 = frames_seen;
        r0 = rd_cnt;
        s0 = frames_started;
        push(8'h3C);
        push(8'($urandom));
        wait_start(s0);
        idle(5 * CPB + CPB / 2 - 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_tx", 32'(tx), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(frame_done), 32'd0);
        idle(3);
        #2 rst_n = 1'b1;
        wait_frames(f0 + 1, "midrst_next");
        idle(5);
        chk("midrst_rd", rd_cnt - r0, 32'd2);

        // Totals
        idle(20);
        chk("exp_queue_drained", exp_q.size(), 32'd0);
        chk("done_pulses", done_cnt, frames_seen);
        chk("total_reads", rd_cnt, wr_ptr);
        chk("final_empty", 32'(fifo_empty), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Serial transmit stage directly downstream of the 64×8 single-clock FIFO. It pops one byte at a time through the FIFO's read strobe and serializes each byte as an asynchronous UART frame: start bit, 8 data bits LSB first, optional even parity, then 1 or 2 stop bits. It runs in the FIFO's clock domain and drives the `tx` pin.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit. Legal values are ≥ 2.
- `PARITY_EN`, default 0: when 1, an even-parity bit is inserted after the data bits.
- `STOP_BITS`, default 1: number of stop bits, 1 or 2.

Ports:
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `tx_en` in 1: permits fetching new bytes from the FIFO.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_data` in 8: FIFO read data; valid in the cycle after `fifo_rd` is asserted.
- `fifo_rd` out 1: FIFO read strobe; registered, one-cycle pulse.
- `tx` out 1: serial line; idles high.
- `busy` out 1: high in every state except IDLE.
- `frame_done` out 1: one-cycle pulse in the last cycle of the final stop bit.

## Operation
- Reset (`rst_n`=0) asynchronously forces:
  - state = IDLE
  - `tx`=1, `fifo_rd`=0, `busy`=0, `frame_done`=0
  - baud counter, bit counter, shift register and parity accumulator cleared to 0
- States: IDLE, FETCH, CAPTURE, START, DATA, PARITY, STOP.
- IDLE: when `tx_en`=1 and `fifo_empty`=0 → FETCH. Otherwise stay in IDLE.
- FETCH: `fifo_rd`=1 for exactly this cycle → CAPTURE.
- CAPTURE: load `fifo_data` into the shift register, clear parity, clear baud counter → START.
- START: `tx`=0 for `CLKS_PER_BIT` cycles → DATA with bit counter = 0.
- DATA: `tx` = shift[0]; XOR it into parity. After `CLKS_PER_BIT` cycles, shift right and increment the bit counter. After bit 7, go to PARITY if `PARITY_EN`, else STOP.
- PARITY: `tx` = XOR of the 8 data bits (even parity) for `CLKS_PER_BIT` cycles → STOP.
- STOP: `tx`=1 for `STOP_BITS`×`CLKS_PER_BIT` cycles. `frame_done` pulses in the final cycle → IDLE.
- Baud counter: width $clog2(`CLKS_PER_BIT`). It counts 0..`CLKS_PER_BIT`-1 and wraps to 0 on each bit boundary. The bit counter is 3 bits and never exceeds 7.
- `tx` is driven from a register; there is no combinational path from inputs to `tx`.
- `tx_en` is sampled only in IDLE. Deasserting it mid-frame completes the current frame, after which the block stays in IDLE.
- `fifo_empty` is sampled only in IDLE. Exactly one read is issued per frame, so the FIFO's registered empty flag is always settled by the next IDLE.
- If `fifo_data` is high-Z/X while not in CAPTURE, it must not affect the block's state.
- Reset asserted mid-frame aborts the frame: `tx` returns high immediately and the byte is lost. The FIFO is not re-read for that byte.

## Timing
- Cycle N: IDLE sees `tx_en`=1 and `fifo_empty`=0.
- Cycle N+1: FETCH, `fifo_rd`=1.
- Cycle N+2: CAPTURE, `fifo_data` sampled at the end of the cycle.
- Cycle N+3: first cycle of `tx`=0.
- Frame length from first start-bit cycle to last stop-bit cycle: (1 + 8 + `PARITY_EN` + `STOP_BITS`) × `CLKS_PER_BIT` cycles.
- Back-to-back bytes: STOP → IDLE → FETCH → CAPTURE inserts 3 extra idle-high cycles between frames. Throughput is therefore one byte per frame length + 3 cycles.
- `busy` rises in FETCH and falls in the cycle after `frame_done`.
- `fifo_rd` is never asserted while `fifo_empty`=1 as sampled in the same IDLE cycle.

## Test plan
- **Reset values:** hold `rst_n`=0 with random inputs → `tx`=1, `fifo_rd`=0, `busy`=0, `frame_done`=0. Release with `fifo_empty`=1 → no `fifo_rd` for 100 cycles.
- **Single byte, defaults:** FIFO holds 0xA5, `CLKS_PER_BIT`=16, `tx_en`=1.
  - `fifo_rd` pulses exactly once.
  - `tx` sequence is 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles.
  - Start bit begins 3 cycles after `fifo_empty` falls.
  - `frame_done` pulses at cycle 160 of the frame.
- **Parity and two stop bits:** `PARITY_EN`=1, `STOP_BITS`=2, bytes 0x07 then 0x00 → parity bits 1 then 0. Each frame is 12×16 = 192 cycles, with 3 idle-high cycles between frames.
- **Back-to-back drain:** push 64 bytes (FIFO full) → exactly 64 `fifo_rd` pulses and 64 frames with matching data in order. `busy` falls only after the last `frame_done`, and the FIFO ends empty.
- **`tx_en` drop mid-frame:** deassert `tx_en` during DATA with 3 bytes queued → the current frame completes. No further `fifo_rd` occurs until `tx_en` is reasserted, then the next byte goes out normally.
- **Reset mid-frame:** assert `rst_n`=0 during bit 4 of 0x3C → `tx`=1 asynchronously, with no `frame_done`. After release, the next queued byte is sent intact.
